// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and fetch-entry layout for the instruction fetch path
package fetch_pkg;

    localparam int BUNDLE_W       = 64;
    localparam int INST_W         = 32;
    localparam int BUNDLE_BYTES   = 8;
    localparam int ADDR_W_DEFAULT = 10;

    // Queue entries carry the bundle's PC above its data.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic [BUNDLE_W-1:0]       data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with flush, count and registered head
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 74,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Upstream credit logic must never push into a full queue.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(do_push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory fetch initiator with PC, credits and redirect
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 4
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    output logic                imem_re_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic [BUNDLE_W-1:0] imem_data_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [BUNDLE_W-1:0] out_data_o,
    output logic [ADDR_W-1:0]   out_pc_o
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic [BUNDLE_W-1:0] data;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_v_q, inflight_v_d;
    logic [CNT_W-1:0]  fq_count;
    logic [CNT_W-1:0]  credits_used;
    logic              issue;
    logic              enq, deq;
    entry_t            enq_entry, head_entry;

    always_comb begin
        // A slot is reserved for every bundle queued or still in flight.
        credits_used  = fq_count + CNT_W'(inflight_v_q);
        issue         = redirect_i | (credits_used < CNT_W'(FQ_DEPTH));
        imem_addr_o   = redirect_i ? redirect_pc_i : pc_q;
        imem_re_o     = issue & reset_n_i;

        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_v_d  = issue;
        if (issue) begin
            pc_d          = imem_addr_o + ADDR_W'(BUNDLE_BYTES);
            inflight_pc_d = imem_addr_o;
        end

        enq            = inflight_v_q & ~redirect_i;
        enq_entry.pc   = inflight_pc_q;
        enq_entry.data = imem_data_i;

        out_valid_o = (fq_count != '0) & ~redirect_i;
        deq         = out_valid_o & out_ready_i;
        out_pc_o    = head_entry.pc;
        out_data_o  = head_entry.data;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_v_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_v_q  <= inflight_v_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fetch_queue (
        .clk_i       (clock_i),
        .rst_ni      (reset_n_i),
        .push_i      (enq),
        .push_data_i (enq_entry),
        .pop_i       (deq),
        .flush_i     (redirect_i),
        .count_o     (fq_count),
        .head_o      (head_entry)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam int ADDR_W   = 10;
    localparam int FQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              imem_re;
    logic [ADDR_W-1:0] imem_addr;
    logic [63:0]       imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [ADDR_W-1:0] out_pc;

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (10'h000),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clock_i       (clk),
        .reset_n_i     (reset_n),
        .imem_re_o     (imem_re),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_pc_o      (out_pc)
    );

    always #5 clk = ~clk;

    // Memory holds byte value == low 8 bits of its address; first byte is the MSB.
    function automatic logic [63:0] bundle(input logic [ADDR_W-1:0] a);
        logic [63:0]       r;
        logic [ADDR_W-1:0] x;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = a + ADDR_W'(i);
            r[63-8*i -: 8] = x[7:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (imem_re) imem_data <= bundle(imem_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Transaction model: every issued fetch owns a slot until handed to decode
    // or flushed; it becomes presentable two cycles after issue.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        int                cyc;
    } ment_t;

    ment_t             mq[$];
    logic [ADDR_W-1:0] m_next_pc = '0;
    int                cyc = 0;

    always @(negedge clk) begin : model
        logic              exp_re, exp_v;
        logic [ADDR_W-1:0] ia;
        if (!reset_n) begin
            mq.delete();
            m_next_pc = 10'h000;
            chk("m_rst_re", 64'(imem_re), 64'(0));
            chk("m_rst_valid", 64'(out_valid), 64'(0));
        end else begin
            exp_re = redirect || (mq.size() < FQ_DEPTH);
            ia     = redirect ? redirect_pc : m_next_pc;
            exp_v  = !redirect && (mq.size() != 0) && (mq[0].cyc <= cyc - 2);
            chk("m_re", 64'(imem_re), 64'(exp_re));
            if (exp_re) chk("m_addr", 64'(imem_addr), 64'(ia));
            chk("m_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v && out_valid) begin
                chk("m_pc", 64'(out_pc), 64'(mq[0].pc));
                chk("m_data", out_data, bundle(mq[0].pc));
            end
            if (redirect) mq.delete();
            else if (exp_v && out_ready) mq.delete(0);
            if (exp_re) begin
                mq.push_back('{pc: ia, cyc: cyc});
                m_next_pc = ia + 10'd8;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int n_iss;
    int cd;

    initial begin
        imem_data   = '0;
        reset_n     = 1'b0;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) step();

        // Streaming from reset release
        reset_n = 1'b1;
        smp();
        chk("t1_re0", 64'(imem_re), 64'(1));
        chk("t1_addr0", 64'(imem_addr), 64'h000);
        chk("t1_valid0", 64'(out_valid), 64'(0));
        step(); smp();
        chk("t1_addr1", 64'(imem_addr), 64'h008);
        chk("t1_valid1", 64'(out_valid), 64'(0));
        step(); smp();
        chk("t1_valid2", 64'(out_valid), 64'(1));
        chk("t1_pc2", 64'(out_pc), 64'h000);
        chk("t1_data2", out_data, 64'h0001020304050607);
        step(); smp();
        chk("t1_pc3", 64'(out_pc), 64'h008);
        chk("t1_data3", out_data, 64'h08090A0B0C0D0E0F);
        chk("t1_addr3", 64'(imem_addr), 64'h018);

        // Stall from reset: exactly FQ_DEPTH fetches, then drain in order
        step(); reset_n = 1'b0; out_ready = 1'b0;
        step(); step(); reset_n = 1'b1;
        n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (imem_re) n_iss++;
            if (i < 7) step();
        end
        chk("t2_issues", 64'(n_iss), 64'(4));
        chk("t2_re_idle", 64'(imem_re), 64'(0));
        step(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_drain_pc", 64'(out_pc), 64'(i * 8));
            if (i == 1) begin
                chk("t2_resume_re", 64'(imem_re), 64'(1));
                chk("t2_resume_addr", 64'(imem_addr), 64'h020);
            end
            step();
        end

        // Redirect with three bundles queued
        reset_n = 1'b0; out_ready = 1'b0;
        step(); reset_n = 1'b1;
        repeat (4) begin smp(); step(); end
        redirect = 1'b1; redirect_pc = 10'h100; out_ready = 1'b1;
        smp();
        chk("t3_valid_r", 64'(out_valid), 64'(0));
        chk("t3_re_r", 64'(imem_re), 64'(1));
        chk("t3_addr_r", 64'(imem_addr), 64'h100);
        step(); redirect = 1'b0; smp();
        chk("t3_valid_r1", 64'(out_valid), 64'(0));
        step(); smp();
        chk("t3_valid_r2", 64'(out_valid), 64'(1));
        chk("t3_pc_r2", 64'(out_pc), 64'h100);
        chk("t3_data_r2", out_data, 64'h0001020304050607);
        step(); smp();
        chk("t3_pc_r3", 64'(out_pc), 64'h108);

        // Wrap across the top of the address space
        step(); redirect = 1'b1; redirect_pc = 10'h3F8; smp();
        chk("t4_addr_r", 64'(imem_addr), 64'h3F8);
        step(); redirect = 1'b0; smp();
        chk("t4_re_wrap", 64'(imem_re), 64'(1));
        chk("t4_addr_wrap", 64'(imem_addr), 64'h000);
        step(); smp();
        chk("t4_pc_3f8", 64'(out_pc), 64'h3F8);
        chk("t4_data_3f8", out_data, 64'hF8F9FAFBFCFDFEFF);
        step(); smp();
        chk("t4_pc_000", 64'(out_pc), 64'h000);
        chk("t4_data_000", out_data, 64'h0001020304050607);

        // Reset mid-stream with the queue non-empty
        step(); out_ready = 1'b0;
        repeat (3) begin smp(); step(); end
        reset_n = 1'b0; smp();
        chk("t5_valid_rst", 64'(out_valid), 64'(0));
        chk("t5_re_rst", 64'(imem_re), 64'(0));
        step(); reset_n = 1'b1; out_ready = 1'b1; smp();
        chk("t5_re0", 64'(imem_re), 64'(1));
        chk("t5_addr0", 64'(imem_addr), 64'h000);
        step(); smp();
        chk("t5_valid1", 64'(out_valid), 64'(0));
        step(); smp();
        chk("t5_valid2", 64'(out_valid), 64'(1));
        chk("t5_pc2", 64'(out_pc), 64'h000);

        // Random backpressure and redirects; the model checks every cycle
        cd = $urandom_range(5, 20);
        for (int i = 0; i < 600; i++) begin
            step();
            out_ready = 1'($urandom_range(0, 1));
            redirect  = 1'b0;
            cd--;
            if (cd == 0) begin
                redirect    = 1'b1;
                redirect_pc = ADDR_W'($urandom_range(0, 255) * 4);
                cd          = $urandom_range(5, 20);
            end
            smp();
        end
        step(); redirect = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
